// File: rtl/surf_cmd_scheduler.sv
// Queues trigger requests, assigns each one a free SURF buffer and launches
// one digitize command at a time to the SURF command serializer.
module surf_cmd_scheduler #(
    parameter int NUM_BUFFERS = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int LAUNCH_GAP  = 2,
    parameter int WAIT_HI_MAX = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   trig_i,
    input  logic [31:0]            trig_event_id_i,
    output logic                   trig_drop_o,
    input  logic                   release_i,
    input  logic [1:0]             release_buffer_i,
    output logic                   cmd_start_o,
    output logic [31:0]            cmd_event_id_o,
    output logic [1:0]             cmd_buffer_o,
    input  logic                   cmd_busy_i,
    output logic [NUM_BUFFERS-1:0] buf_busy_o,
    output logic [4:0]             queue_count_o,
    output logic                   dead_o,
    output logic [15:0]            drop_count_o,
    output logic                   error_o
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int TW = 8;

    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO, GAP} state_t;

    state_t                 state;
    logic [31:0]            mem [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_next;
    logic [NUM_BUFFERS-1:0] busy_vec;
    logic [NUM_BUFFERS-1:0] busy_next;
    logic [TW-1:0]          timer;
    logic                   full;
    logic                   push;
    logic                   pop;
    logic                   can_launch;
    logic                   free_any;
    logic [1:0]             free_idx;

    // A full FIFO drops the request even when a pop frees a slot this cycle.
    assign full       = (count == CW'(FIFO_DEPTH));
    assign push       = trig_i && !full;
    assign can_launch = (state == IDLE) && (count != '0) && free_any;
    assign pop        = can_launch;
    assign count_next = count + CW'(push) - CW'(pop);

    assign buf_busy_o    = busy_vec;
    assign queue_count_o = 5'(count);

    always_comb begin
        free_any = 1'b0;
        free_idx = 2'd0;
        for (int i = NUM_BUFFERS - 1; i >= 0; i--) begin
            if (!busy_vec[i]) begin
                free_any = 1'b1;
                free_idx = 2'(i);
            end
        end
    end

    // Allocation indexes the pre-release vector, so a buffer freed this
    // cycle only becomes allocatable from the next cycle on.
    always_comb begin
        busy_next = busy_vec;
        if (release_i) begin
            busy_next[release_buffer_i] = 1'b0;
        end
        if (can_launch) begin
            busy_next[free_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= trig_event_id_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            busy_vec       <= '0;
            timer          <= '0;
            trig_drop_o    <= 1'b0;
            drop_count_o   <= '0;
            dead_o         <= 1'b0;
            error_o        <= 1'b0;
            cmd_start_o    <= 1'b0;
            cmd_event_id_o <= '0;
            cmd_buffer_o   <= '0;
        end else begin
            count    <= count_next;
            busy_vec <= busy_next;
            dead_o   <= (&busy_next) && (count_next != '0);
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            trig_drop_o <= trig_i && full;
            if (trig_i && full && (drop_count_o != 16'hFFFF)) begin
                drop_count_o <= drop_count_o + 16'd1;
            end

            cmd_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (can_launch) begin
                        state          <= LAUNCH;
                        cmd_start_o    <= 1'b1;
                        cmd_event_id_o <= mem[rd_ptr];
                        cmd_buffer_o   <= free_idx;
                    end
                end
                LAUNCH: begin
                    state <= WAIT_HI;
                    timer <= '0;
                end
                WAIT_HI: begin
                    if (cmd_busy_i) begin
                        state <= WAIT_LO;
                    end else if (timer == TW'(WAIT_HI_MAX - 1)) begin
                        // The buffer stays allocated; readout must release it.
                        error_o <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_LO: begin
                    if (!cmd_busy_i) begin
                        timer <= '0;
                        state <= (LAUNCH_GAP == 0) ? IDLE : GAP;
                    end
                end
                GAP: begin
                    if (timer == TW'(LAUNCH_GAP - 1)) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_surf_cmd_scheduler.sv
// Directed bench for surf_cmd_scheduler with a serializer model that holds
// busy for 36 cycles starting the cycle after each start pulse.
module tb_surf_cmd_scheduler;

    localparam int BUSY_LEN = 36;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        trig = 1'b0;
    logic [31:0] trig_id = '0;
    logic        trig_drop;
    logic        rel = 1'b0;
    logic [1:0]  rel_buf = '0;
    logic        cmd_start;
    logic [31:0] cmd_event_id;
    logic [1:0]  cmd_buffer;
    logic        cmd_busy = 1'b0;
    logic [3:0]  buf_busy;
    logic [4:0]  queue_count;
    logic        dead;
    logic [15:0] drop_count;
    logic        error;

    logic        ser_en = 1'b1;
    int          cyc = 0;
    int          t0 = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] id;
        logic        exp_drop;
        logic [4:0]  exp_count;
        logic [15:0] exp_drops;
    } burst_vec_t;

    typedef struct {
        logic [31:0] exp_id;
        logic [1:0]  exp_buf;
    } launch_vec_t;

    burst_vec_t  burst [6];
    launch_vec_t launches [4];

    surf_cmd_scheduler dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .trig_i           (trig),
        .trig_event_id_i  (trig_id),
        .trig_drop_o      (trig_drop),
        .release_i        (rel),
        .release_buffer_i (rel_buf),
        .cmd_start_o      (cmd_start),
        .cmd_event_id_o   (cmd_event_id),
        .cmd_buffer_o     (cmd_buffer),
        .cmd_busy_i       (cmd_busy),
        .buf_busy_o       (buf_busy),
        .queue_count_o    (queue_count),
        .dead_o           (dead),
        .drop_count_o     (drop_count),
        .error_o          (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Serializer model: busy rises the cycle after start and holds BUSY_LEN cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (cmd_start && ser_en) begin
                @(posedge clk);
                #1;
                cmd_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1;
                cmd_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_cycle(input int k);
        while ((cyc - t0) < k) step();
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic t, input logic [31:0] id,
                                 input logic r, input logic [1:0] rb);
        trig    = t;
        trig_id = id;
        rel     = r;
        rel_buf = rb;
        step();
        trig    = 1'b0;
        trig_id = '0;
        rel     = 1'b0;
        rel_buf = '0;
    endtask

    task automatic wait_start(input string name, input int max_cycles);
        int n = 0;
        while (!cmd_start && n < max_cycles) begin
            step();
            n++;
        end
        checkOutput({name, "_start_seen"}, 32'(cmd_start), 32'd1);
    endtask

    task automatic check_all_zero(input string p);
        checkOutput({p, "_start"}, 32'(cmd_start), 32'd0);
        checkOutput({p, "_event_id"}, cmd_event_id, 32'd0);
        checkOutput({p, "_buffer"}, 32'(cmd_buffer), 32'd0);
        checkOutput({p, "_drop"}, 32'(trig_drop), 32'd0);
        checkOutput({p, "_buf_busy"}, 32'(buf_busy), 32'd0);
        checkOutput({p, "_count"}, 32'(queue_count), 32'd0);
        checkOutput({p, "_dead"}, 32'(dead), 32'd0);
        checkOutput({p, "_drop_count"}, 32'(drop_count), 32'd0);
        checkOutput({p, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic do_reset();
        int n = 0;
        while (cmd_busy && n < 100) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        int starts;

        burst[0] = '{32'd1, 1'b0, 5'd1, 16'd0};
        burst[1] = '{32'd2, 1'b0, 5'd2, 16'd0};
        burst[2] = '{32'd3, 1'b0, 5'd3, 16'd0};
        burst[3] = '{32'd4, 1'b0, 5'd4, 16'd0};
        burst[4] = '{32'd5, 1'b1, 5'd4, 16'd1};
        burst[5] = '{32'd6, 1'b1, 5'd3, 16'd2};
        launches[0] = '{32'd1, 2'd0};
        launches[1] = '{32'd2, 2'd1};
        launches[2] = '{32'd3, 2'd2};
        launches[3] = '{32'd4, 2'd3};

        repeat (2) step();
        check_all_zero("reset");
        rst_n = 1'b1;
        step();

        $display("[TB] single trigger latency and launch spacing");
        t0 = cyc;
        applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 2'd0);
        checkOutput("t1_count_c1", 32'(queue_count), 32'd1);
        checkOutput("t1_start_c1", 32'(cmd_start), 32'd0);
        to_cycle(2);
        checkOutput("t1_start_c2", 32'(cmd_start), 32'd1);
        checkOutput("t1_buffer", 32'(cmd_buffer), 32'd0);
        checkOutput("t1_event_id", cmd_event_id, 32'hDEADBEEF);
        checkOutput("t1_buf_busy", 32'(buf_busy), 32'b0001);
        applyStimulus(1'b1, 32'h12345678, 1'b0, 2'd0);
        checkOutput("t1_start_c3", 32'(cmd_start), 32'd0);
        to_cycle(20);
        checkOutput("t1_event_id_hold", cmd_event_id, 32'hDEADBEEF);
        wait_start("t1_second", 80);
        checkOutput("t1_second_cycle", 32'(cyc - t0), 32'(2 + BUSY_LEN + 2 + 3));
        checkOutput("t1_second_buffer", 32'(cmd_buffer), 32'd1);
        checkOutput("t1_second_event_id", cmd_event_id, 32'h12345678);
        repeat (45) step();
        do_reset();

        // Warm-up command keeps the FSM out of IDLE until the burst fills the FIFO.
        $display("[TB] six-trigger burst against a full FIFO");
        t0 = cyc;
        applyStimulus(1'b1, 32'hA0, 1'b0, 2'd0);
        to_cycle(10);
        applyStimulus(1'b0, 32'd0, 1'b1, 2'd0);
        checkOutput("t2_released", 32'(buf_busy), 32'd0);
        to_cycle(37);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, burst[i].id, 1'b0, 2'd0);
            checkOutput($sformatf("burst%0d_drop", i), 32'(trig_drop), 32'(burst[i].exp_drop));
            checkOutput($sformatf("burst%0d_count", i), 32'(queue_count), 32'(burst[i].exp_count));
            checkOutput($sformatf("burst%0d_drop_count", i), 32'(drop_count), 32'(burst[i].exp_drops));
        end
        for (int i = 0; i < 4; i++) begin
            wait_start($sformatf("launch%0d", i), 60);
            checkOutput($sformatf("launch%0d_event_id", i), cmd_event_id, launches[i].exp_id);
            checkOutput($sformatf("launch%0d_buffer", i), 32'(cmd_buffer), 32'(launches[i].exp_buf));
            step();
        end
        checkOutput("t2_all_busy", 32'(buf_busy), 32'b1111);
        checkOutput("t2_drop_count_final", 32'(drop_count), 32'd2);
        repeat (45) step();
        checkOutput("t2_dead_empty", 32'(dead), 32'd0);

        $display("[TB] dead condition and release-driven launch");
        applyStimulus(1'b1, 32'h77, 1'b0, 2'd0);
        checkOutput("t3_count", 32'(queue_count), 32'd1);
        checkOutput("t3_dead", 32'(dead), 32'd1);
        starts = 0;
        repeat (10) begin
            if (cmd_start) starts++;
            step();
        end
        checkOutput("t3_no_start_dead", 32'(starts), 32'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 2'd2);
        checkOutput("t3_busy_after_release", 32'(buf_busy), 32'b1011);
        checkOutput("t3_dead_fell", 32'(dead), 32'd0);
        step();
        checkOutput("t3_start", 32'(cmd_start), 32'd1);
        checkOutput("t3_buffer", 32'(cmd_buffer), 32'd2);
        checkOutput("t3_event_id", cmd_event_id, 32'h77);
        checkOutput("t3_busy_full", 32'(buf_busy), 32'b1111);
        repeat (45) step();
        do_reset();

        $display("[TB] release and allocation on the same edge");
        applyStimulus(1'b1, 32'hB0, 1'b0, 2'd0);
        applyStimulus(1'b1, 32'hB1, 1'b0, 2'd0);
        wait_start("t4_first", 10);
        checkOutput("t4_first_buffer", 32'(cmd_buffer), 32'd0);
        step();
        wait_start("t4_second", 60);
        checkOutput("t4_second_buffer", 32'(cmd_buffer), 32'd1);
        repeat (45) step();
        applyStimulus(1'b1, 32'hB2, 1'b0, 2'd0);
        applyStimulus(1'b0, 32'd0, 1'b1, 2'd1);
        checkOutput("t4_start", 32'(cmd_start), 32'd1);
        checkOutput("t4_buffer", 32'(cmd_buffer), 32'd2);
        checkOutput("t4_buf_busy", 32'(buf_busy), 32'b0101);
        repeat (45) step();
        do_reset();

        $display("[TB] serializer never raises busy");
        ser_en = 1'b0;
        t0 = cyc;
        applyStimulus(1'b1, 32'hE0, 1'b0, 2'd0);
        to_cycle(2);
        checkOutput("t5_start", 32'(cmd_start), 32'd1);
        to_cycle(6);
        checkOutput("t5_error_before", 32'(error), 32'd0);
        to_cycle(7);
        checkOutput("t5_error_after", 32'(error), 32'd1);
        checkOutput("t5_buf_busy", 32'(buf_busy), 32'b0001);
        applyStimulus(1'b1, 32'hE1, 1'b0, 2'd0);
        to_cycle(9);
        checkOutput("t5_relaunch_start", 32'(cmd_start), 32'd1);
        checkOutput("t5_relaunch_buffer", 32'(cmd_buffer), 32'd1);
        checkOutput("t5_error_sticky", 32'(error), 32'd1);
        repeat (10) step();
        do_reset();
        ser_en = 1'b1;

        $display("[TB] reset asserted during WAIT_LO");
        t0 = cyc;
        applyStimulus(1'b1, 32'hC0, 1'b0, 2'd0);
        applyStimulus(1'b1, 32'hC1, 1'b0, 2'd0);
        applyStimulus(1'b1, 32'hC2, 1'b0, 2'd0);
        checkOutput("t6_queued", 32'(queue_count), 32'd2);
        to_cycle(10);
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_reset");
        repeat (3) step();
        rst_n = 1'b1;
        starts = 0;
        repeat (50) begin
            step();
            if (cmd_start) starts++;
        end
        checkOutput("t6_no_start_after_reset", 32'(starts), 32'd0);
        checkOutput("t6_count_after_reset", 32'(queue_count), 32'd0);
        t0 = cyc;
        applyStimulus(1'b1, 32'hD0, 1'b0, 2'd0);
        to_cycle(2);
        checkOutput("t6_new_start", 32'(cmd_start), 32'd1);
        checkOutput("t6_new_buffer", 32'(cmd_buffer), 32'd0);
        checkOutput("t6_new_event_id", cmd_event_id, 32'hD0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/surf_cmd_scheduler.md
# surf_cmd_scheduler

Sequences digitize commands to the SURF command serializer. Trigger requests carry a 32-bit event ID and go into a small FIFO. The block allocates one of four SURF buffers to each request and launches one serial command at a time. Buffers are freed by readout release strobes. It sits between the TURF trigger/event-numbering logic and the SURF command serializer, and drives that serializer's start, event ID and buffer inputs.

## Interface
- NUM_BUFFERS, 4: SURF buffers tracked; fixed at 4 because the buffer ID is 2 bits.
- FIFO_DEPTH, 4: pending trigger requests; must be a power of 2, 2..16.
- LAUNCH_GAP, 2: idle cycles enforced after the serializer drops busy, before the next launch; 0 allowed.
- WAIT_HI_MAX, 4: cycles allowed for the serializer to raise busy after start.

Ports:
- clk_i  in  1  system clock, all logic rising-edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- trig_i  in  1  one-cycle request strobe.
- trig_event_id_i  in  32  event ID, sampled with trig_i.
- trig_drop_o  out  1  one-cycle pulse, request dropped because the FIFO was full.
- release_i  in  1  one-cycle strobe, readout finished with a buffer.
- release_buffer_i  in  2  index of the buffer being released.
- cmd_start_o  out  1  one-cycle start to the serializer.
- cmd_event_id_o  out  32  event ID for the serializer; registered.
- cmd_buffer_o  out  2  buffer ID for the serializer; registered.
- cmd_busy_i  in  1  serializer busy level.
- buf_busy_o  out  4  per-buffer allocated flags.
- queue_count_o  out  5  FIFO occupancy.
- dead_o  out  1  all buffers allocated and FIFO non-empty.
- drop_count_o  out  16  saturating count of dropped requests.
- error_o  out  1  sticky; set when busy never rose after a start.

## Operation
- Reset (async assert) sets every output to 0: the FSM is in IDLE, the FIFO is flushed, all buffers are free, drop_count_o and error_o are cleared.
- Reset asserted mid-command drops cmd_start_o immediately. A frame already shifting in the serializer is not aborted by this block.
- FIFO push on trig_i when the count sampled at the start of that cycle is below FIFO_DEPTH.
- If the count equals FIFO_DEPTH, the request is dropped, even if a pop happens in the same cycle. trig_drop_o pulses and drop_count_o increments, saturating at 0xFFFF.
- Buffer allocation always takes the lowest-index free buffer.
- release_i clears buf_busy_o[release_buffer_i] at the next edge. Releasing a buffer that is already free is ignored.
- Allocation and release in the same cycle are both applied. Allocation sees the pre-release vector, so a buffer being released cannot be reallocated in that cycle.
- FSM states: IDLE, LAUNCH, WAIT_HI, WAIT_LO, GAP.
- IDLE -> LAUNCH: FIFO non-empty and a free buffer exists. On this edge:
  - register cmd_event_id_o (FIFO head) and cmd_buffer_o (allocated index);
  - set that buffer's busy bit;
  - pop the FIFO.
- LAUNCH: cmd_start_o = 1 for exactly this cycle; next state WAIT_HI.
- WAIT_HI -> WAIT_LO when cmd_busy_i = 1.
- WAIT_HI timeout: after WAIT_HI_MAX cycles without busy, set error_o and go to IDLE. The allocated buffer stays busy.
- WAIT_LO -> GAP when cmd_busy_i = 0. GAP then lasts LAUNCH_GAP cycles (skipped when LAUNCH_GAP = 0), then IDLE.
- cmd_event_id_o and cmd_buffer_o hold their values from the LAUNCH cycle until the next IDLE->LAUNCH edge.
- dead_o = (&buf_busy_o) && (queue_count_o != 0); registered.

## Timing
- Latency: trig_i in cycle 0 with an empty FIFO, IDLE state and a free buffer gives cmd_start_o in cycle 2.
- buf_busy_o updates in cycle 2.
- The serializer raises busy in cycle 3, which is normally the first WAIT_HI cycle.
- A full serializer frame holds busy for about 36 cycles.
- Back-to-back launch spacing = busy duration + LAUNCH_GAP + 3 cycles.
- Only one command is outstanding at a time; cmd_start_o is never asserted while cmd_busy_i = 1.
- FIFO pointers wrap modulo FIFO_DEPTH. queue_count_o is one bit wider than the pointers so that full is distinguishable from empty.

## Test plan
- Single trigger, ID 0xDEADBEEF, after reset:
  - cmd_start_o in cycle 2 with cmd_buffer_o = 0 and cmd_event_id_o = 0xDEADBEEF;
  - buf_busy_o = 0001;
  - model busy held 36 cycles; the next launch is possible no earlier than 2 cycles after busy falls.
- Six triggers in consecutive cycles, no releases, FIFO_DEPTH = 4, IDs 1..6:
  - IDs 1..4 are accepted; IDs 5 and 6 are dropped with two trig_drop_o pulses and drop_count_o = 2;
  - launches go to buffers 0, 1, 2, 3 in order.
- All four buffers busy and one request pending:
  - dead_o = 1 and no start is issued;
  - release_i with buffer 2 gives a launch on buffer 2 two cycles later, and dead_o falls.
- Serializer model that never raises busy:
  - error_o = 1 after 4 WAIT_HI cycles, then the FSM returns to IDLE;
  - buf_busy_o[0] stays 1.
- rst_n_i pulled low during WAIT_LO with two requests queued:
  - all outputs are 0 immediately;
  - after reset is released there are no starts until a new trig_i.
- release_i on buffer 1 in the same cycle as an allocation while buffers 0 and 1 are busy:
  - the allocation goes to buffer 2;
  - buf_busy_o = 0101 the next cycle.
